// File: rtl/gpio_in_debounce.sv
// Debounced GPIO input peripheral: 2-FF synchroniser and debounce counter per pin,
// W1C rise/fall status, per-edge IRQ enables and a registered level interrupt.
module gpio_in_debounce #(
    parameter int N_PINS          = 16,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              r_en_i,
    input  logic              w_en_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       w_data_i,
    input  logic [N_PINS-1:0] pin_i,
    output logic [31:0]       r_data_o,
    output logic              irq_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;
    localparam logic [1:0] REG_RAW    = 2'd3;

    logic [N_PINS-1:0] meta;
    logic [N_PINS-1:0] sync;
    logic [N_PINS-1:0] stable;
    logic [N_PINS-1:0] accept;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] rise_pend;
    logic [N_PINS-1:0] fall_pend;
    logic [N_PINS-1:0] rise_en;
    logic [N_PINS-1:0] fall_en;
    logic [N_PINS-1:0] rise_clr;
    logic [N_PINS-1:0] fall_clr;

    logic       rd;
    logic       wr;
    logic [1:0] sel;
    logic       unused_bits;

    assign rd  = en_i & r_en_i;
    assign wr  = en_i & w_en_i;
    assign sel = addr_i[3:2];
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], w_data_i};

    function automatic logic [15:0] pad(input logic [N_PINS-1:0] v);
        logic [15:0] ext;
        ext = '0;
        ext[N_PINS-1:0] = v;
        return ext;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= pin_i;
            sync <= meta;
        end
    end

    // A pin is accepted only after sync has differed from stable for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the stable value restarts the count.
    for (genvar i = 0; i < N_PINS; i++) begin : g_pin
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (sync[i] == stable[i]) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign accept[i] = (sync[i] != stable[i]) && (cnt == CNT_MAX);
    end

    assign rise = accept & sync;
    assign fall = accept & ~sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
        end else begin
            stable <= stable ^ accept;
        end
    end

    assign rise_clr = (wr && sel == REG_STATUS) ? w_data_i[N_PINS-1:0]       : '0;
    assign fall_clr = (wr && sel == REG_STATUS) ? w_data_i[16+N_PINS-1:16]   : '0;

    // New edges are OR-ed in after the clear so a same-cycle edge always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pend <= '0;
            fall_pend <= '0;
        end else begin
            rise_pend <= (rise_pend & ~rise_clr) | rise;
            fall_pend <= (fall_pend & ~fall_clr) | fall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_en <= '0;
            fall_en <= '0;
        end else if (wr && sel == REG_IRQ_EN) begin
            rise_en <= w_data_i[N_PINS-1:0];
            fall_en <= w_data_i[16+N_PINS-1:16];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |((rise_pend & rise_en) | (fall_pend & fall_en));
        end
    end

    always_comb begin
        r_data_o = '0;
        if (rd) begin
            case (sel)
                REG_DATA:   r_data_o = {16'h0, pad(stable)};
                REG_STATUS: r_data_o = {pad(fall_pend), pad(rise_pend)};
                REG_IRQ_EN: r_data_o = {pad(fall_en), pad(rise_en)};
                REG_RAW:    r_data_o = {16'h0, pad(sync)};
                default:    r_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboard bench for gpio_in_debounce with DEBOUNCE_CYCLES=4: expected register
// and irq values are queued as stimulus is applied and popped as the DUT is sampled.
module tb_gpio_in_debounce;

    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_IRQ_EN = 32'h8;
    localparam logic [31:0] A_RAW    = 32'hC;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        r_en;
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [15:0] pin;
    logic [31:0] r_data;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] got;
    int          checks   = 0;
    int          failures = 0;

    gpio_in_debounce #(
        .N_PINS(16),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en_i(en),
        .r_en_i(r_en),
        .w_en_i(w_en),
        .addr_i(addr),
        .w_data_i(w_data),
        .pin_i(pin),
        .r_data_o(r_data),
        .irq_o(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, summary not produced");
        $fatal(1, "[TB] watchdog");
    end

    // All sampling and driving happens 1 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; w_en = 1'b1; addr = a; w_data = d;
        tick(1);
        en = 1'b0; w_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        en = 1'b1; r_en = 1'b1; addr = a;
        #1;
        d = r_data;
        en = 1'b0; r_en = 1'b0;
    endtask

    task automatic expect_val(input string name, input logic [31:0] v);
        exp_q.push_back('{name, v});
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; r_en = 1'b0; w_en = 1'b0;
        addr = '0; w_data = '0; pin = '0;
        tick(2);
        expect_val("reset_data", 32'h0);
        expect_val("reset_status", 32'h0);
        expect_val("reset_irq_en", 32'h0);
        expect_val("reset_raw", 32'h0);
        expect_val("reset_irq", 32'h0);
        expect_val("reset_idle_rdata", 32'h0);
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_IRQ_EN, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_RAW, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        got = {31'b0, irq};
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        got = r_data;
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_latency;
        pin[0] = 1'b1;
        expect_val("latency_data_edge5", 32'h0);
        expect_val("latency_data_edge6", 32'h1);
        expect_val("latency_status", 32'h0000_0001);
        expect_val("latency_irq_disabled", 32'h0);
        tick(5);
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        tick(1);
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        got = {31'b0, irq};
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    endtask

    task automatic test_glitch;
        bus_write(A_STATUS, 32'hFFFF_FFFF);
        pin[3] = 1'b1;
        tick(3);
        pin[3] = 1'b0;
        expect_val("glitch3_status", 32'h0);
        expect_val("glitch3_data", 32'h1);
        tick(8);
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        pin[3] = 1'b1;
        tick(4);
        pin[3] = 1'b0;
        expect_val("pulse4_data_accepted", 32'h9);
        expect_val("pulse4_status_rise_fall", 32'h0008_0008);
        expect_val("pulse4_data_released", 32'h1);
        tick(2);
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        tick(6);
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    endtask

    task automatic test_irq;
        bus_write(A_STATUS, 32'hFFFF_FFFF);
        bus_write(A_IRQ_EN, 32'h0001_0000);
        pin[0] = 1'b0;
        expect_val("irq_fall_status", 32'h0001_0000);
        expect_val("irq_not_yet", 32'h0);
        expect_val("irq_asserted", 32'h1);
        expect_val("irq_held_at_clear_edge", 32'h1);
        expect_val("irq_status_cleared", 32'h0);
        expect_val("irq_dropped", 32'h0);
        tick(6);
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        got = {31'b0, irq};
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        tick(1);
        got = {31'b0, irq};
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_write(A_STATUS, 32'h0001_0000);
        got = {31'b0, irq};
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        tick(1);
        got = {31'b0, irq};
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_write(A_IRQ_EN, 32'h0);
    endtask

    task automatic test_w1c_priority;
        pin[0] = 1'b1;
        expect_val("w1c_same_cycle_edge_wins", 32'h1);
        expect_val("w1c_clear_works", 32'h0);
        tick(5);
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    endtask

    task automatic test_registers;
        bus_write(A_DATA, 32'hFFFF_FFFF);
        bus_write(A_RAW, 32'hFFFF_FFFF);
        expect_val("ro_data_unchanged", 32'h1);
        expect_val("ro_raw_unchanged", 32'h1);
        expect_val("ro_irq_en_untouched", 32'h0);
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_RAW, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_IRQ_EN, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_write(A_IRQ_EN, 32'h1234_5678);
        expect_val("irq_en_readback", 32'h1234_5678);
        expect_val("rw_same_cycle_pre_write", 32'h1234_5678);
        expect_val("rw_same_cycle_post_write", 32'hAAAA_5555);
        expect_val("no_select_rdata_zero", 32'h0);
        bus_read(A_IRQ_EN, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        en = 1'b1; r_en = 1'b1; w_en = 1'b1; addr = A_IRQ_EN; w_data = 32'hAAAA_5555;
        #1;
        got = r_data;
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        tick(1);
        en = 1'b0; r_en = 1'b0; w_en = 1'b0;
        bus_read(A_IRQ_EN, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        r_en = 1'b1; addr = A_IRQ_EN;
        #1;
        got = r_data;
        r_en = 1'b0;
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_write(A_IRQ_EN, 32'h0);
    endtask

    task automatic test_reset_mid_debounce;
        bus_write(A_IRQ_EN, 32'h0000_0020);
        pin[5] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        expect_val("midrst_data", 32'h0);
        expect_val("midrst_irq_en", 32'h0);
        expect_val("midrst_status", 32'h0);
        expect_val("midrst_irq", 32'h0);
        expect_val("midrst_data_edge5", 32'h0);
        expect_val("midrst_data_edge6", 32'h21);
        expect_val("midrst_status_edge6", 32'h21);
        #1;
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_IRQ_EN, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        got = {31'b0, irq};
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        tick(1);
        rst_n = 1'b1;
        tick(5);
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        tick(1);
        bus_read(A_DATA, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
        bus_read(A_STATUS, got);
        e = exp_q.pop_front(); checks++; if (got !== e.val) begin failures++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_irq();
        test_w1c_priority();
        test_registers();
        test_reset_mid_debounce();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover expectations, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
